// File: rtl/barrier_bus_initiator.sv
// Core-side barrier initiator: turns configure / arrive / read-status commands into
// single-outstanding req/gnt/r_valid bus transactions and waits for the barrier event.
module barrier_bus_initiator #(
  parameter int unsigned            NB_CORES   = 8,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int unsigned            CORE_ID    = 0,
  parameter int unsigned            TIMEOUT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [NB_CORES-1:0]   cmd_trig_mask_i,
  input  logic [NB_CORES-1:0]   cmd_tgt_mask_i,
  input  logic [TIMEOUT_W-1:0]  cmd_timeout_i,
  output logic                  rsp_valid_o,
  output logic [NB_CORES-1:0]   rsp_data_o,
  output logic                  rsp_error_o,
  input  logic                  barrier_event_i,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] bus_add_o,
  output logic                  bus_wen_o,
  output logic [31:0]           bus_wdata_o,
  output logic [3:0]            bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_r_valid_i,
  input  logic [31:0]           bus_r_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TRIG_MASK = BASE_ADDR + ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS    = BASE_ADDR + ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TGT_MASK  = BASE_ADDR + ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TRIGGER   = BASE_ADDR + ADDR_WIDTH'(32'h10);
  localparam logic [NB_CORES-1:0]   ARRIVE_MASK    = {{(NB_CORES-1){1'b0}}, 1'b1} << CORE_ID;
  localparam logic [TIMEOUT_W-1:0]  CNT_ONE        = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG_TRIG, ST_CFG_TGT, ST_ARRIVE, ST_WAIT_EVT, ST_RD, ST_RESP
  } state_e;

  function automatic logic [31:0] mask_to_word(input logic [NB_CORES-1:0] mask);
    logic [31:0] word;
    word = 32'h0;
    word[NB_CORES-1:0] = mask;
    return word;
  endfunction

  state_e                  state_r, state_n;
  logic                    cmd_ready_r, cmd_ready_n;
  logic                    rsp_valid_r, rsp_valid_n;
  logic [NB_CORES-1:0]     rsp_data_r, rsp_data_n;
  logic                    rsp_error_r, rsp_error_n;
  logic                    bus_req_r, req_n;
  logic [ADDR_WIDTH-1:0]   bus_add_r, add_n;
  logic                    bus_wen_r, wen_n;
  logic [31:0]             bus_wdata_r, wdata_n;
  logic                    gnt_seen_r, gnt_seen_n;
  logic                    latch_r, latch_n;
  logic [TIMEOUT_W-1:0]    cnt_r, cnt_n;
  logic [TIMEOUT_W-1:0]    timeout_r, timeout_n;
  logic [NB_CORES-1:0]     tgt_r, tgt_n;
  logic                    done_s;
  logic                    armed_s;
  logic                    rdata_unused_s;

  assign rdata_unused_s = ^bus_r_rdata_i[31:NB_CORES];

  assign cmd_ready_o = cmd_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_error_o = rsp_error_r;
  assign bus_req_o   = bus_req_r;
  assign bus_add_o   = bus_add_r;
  assign bus_wen_o   = bus_wen_r;
  assign bus_wdata_o = bus_wdata_r;
  assign bus_be_o    = 4'hF;

  // Next-state, bus handshake, event latch and response generation.
  always_comb begin
    state_n     = state_r;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_r;
    rsp_error_n = rsp_error_r;
    req_n       = bus_req_r;
    add_n       = bus_add_r;
    wen_n       = bus_wen_r;
    wdata_n     = bus_wdata_r;
    gnt_seen_n  = gnt_seen_r;
    latch_n     = latch_r;
    cnt_n       = cnt_r;
    timeout_n   = timeout_r;
    tgt_n       = tgt_r;
    armed_s     = 1'b0;
    // r_valid only counts once the grant has been seen in an earlier cycle
    done_s      = gnt_seen_r & bus_r_valid_i;

    if (bus_req_r && bus_gnt_i) begin
      req_n      = 1'b0;
      gnt_seen_n = 1'b1;
    end else begin
      req_n = bus_req_r;
    end

    // The latch arms in the arrive grant cycle and stays armed through the wait.
    if ((state_r == ST_ARRIVE && (gnt_seen_r || (bus_req_r && bus_gnt_i))) ||
        state_r == ST_WAIT_EVT) begin
      armed_s = 1'b1;
    end else begin
      armed_s = 1'b0;
    end
    if (armed_s && barrier_event_i) begin
      latch_n = 1'b1;
    end else begin
      latch_n = latch_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          tgt_n      = cmd_tgt_mask_i;
          timeout_n  = cmd_timeout_i;
          gnt_seen_n = 1'b0;
          case (cmd_op_i)
            2'b00: begin
              state_n = ST_CFG_TRIG;
              req_n   = 1'b1;
              add_n   = ADDR_TRIG_MASK;
              wen_n   = 1'b0;
              wdata_n = mask_to_word(cmd_trig_mask_i);
            end
            2'b01: begin
              state_n = ST_ARRIVE;
              req_n   = 1'b1;
              add_n   = ADDR_TRIGGER;
              wen_n   = 1'b0;
              wdata_n = mask_to_word(ARRIVE_MASK);
            end
            2'b10: begin
              state_n = ST_RD;
              req_n   = 1'b1;
              add_n   = ADDR_STATUS;
              wen_n   = 1'b1;
              wdata_n = 32'h0;
            end
            default: begin
              state_n     = ST_RESP;
              rsp_valid_n = 1'b1;
              rsp_error_n = 1'b1;
              rsp_data_n  = {NB_CORES{1'b0}};
            end
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CFG_TRIG: begin
        if (done_s) begin
          state_n    = ST_CFG_TGT;
          req_n      = 1'b1;
          add_n      = ADDR_TGT_MASK;
          wen_n      = 1'b0;
          wdata_n    = mask_to_word(tgt_r);
          gnt_seen_n = 1'b0;
        end else begin
          state_n = ST_CFG_TRIG;
        end
      end
      ST_CFG_TGT: begin
        if (done_s) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_error_n = 1'b0;
          rsp_data_n  = {NB_CORES{1'b0}};
        end else begin
          state_n = ST_CFG_TGT;
        end
      end
      ST_ARRIVE: begin
        if (done_s) begin
          state_n = ST_WAIT_EVT;
          cnt_n   = {TIMEOUT_W{1'b0}};
        end else begin
          state_n = ST_ARRIVE;
        end
      end
      ST_WAIT_EVT: begin
        // An event in the expiry cycle takes priority over the timeout.
        if (barrier_event_i || latch_r) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_error_n = 1'b0;
          rsp_data_n  = {NB_CORES{1'b0}};
        end else if (timeout_r != {TIMEOUT_W{1'b0}} && cnt_r == timeout_r - CNT_ONE) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_error_n = 1'b1;
          rsp_data_n  = {NB_CORES{1'b0}};
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      ST_RD: begin
        if (done_s) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_error_n = 1'b0;
          rsp_data_n  = bus_r_rdata_i[NB_CORES-1:0];
        end else begin
          state_n = ST_RD;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
        latch_n = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {NB_CORES{1'b0}};
      rsp_error_r <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_add_r   <= {ADDR_WIDTH{1'b0}};
      bus_wen_r   <= 1'b1;
      bus_wdata_r <= 32'h0;
      gnt_seen_r  <= 1'b0;
      latch_r     <= 1'b0;
      cnt_r       <= {TIMEOUT_W{1'b0}};
      timeout_r   <= {TIMEOUT_W{1'b0}};
      tgt_r       <= {NB_CORES{1'b0}};
    end else begin
      state_r     <= state_n;
      cmd_ready_r <= cmd_ready_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_data_r  <= rsp_data_n;
      rsp_error_r <= rsp_error_n;
      bus_req_r   <= req_n;
      bus_add_r   <= add_n;
      bus_wen_r   <= wen_n;
      bus_wdata_r <= wdata_n;
      gnt_seen_r  <= gnt_seen_n;
      latch_r     <= latch_n;
      cnt_r       <= cnt_n;
      timeout_r   <= timeout_n;
      tgt_r       <= tgt_n;
    end
  end

endmodule

// File: tb/tb_barrier_bus_initiator.sv
// Scoreboard bench for barrier_bus_initiator: a bus slave model with programmable
// grant/response delays, and expected bus transactions and responses queued per test.
module tb_barrier_bus_initiator;
  localparam int          NB   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct packed {
    logic [NB-1:0] data;
    logic          err;
    logic [31:0]   c;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [NB-1:0] cmd_trig = 8'h00;
  logic [NB-1:0] cmd_tgt = 8'h00;
  logic [15:0]   cmd_timeout = 16'd0;
  logic          rsp_valid;
  logic [NB-1:0] rsp_data;
  logic          rsp_error;
  logic          barrier_event = 1'b0;
  logic          bus_req;
  logic [31:0]   bus_add;
  logic          bus_wen;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_gnt = 1'b0;
  logic          bus_r_valid = 1'b0;
  logic [31:0]   bus_r_rdata = 32'h0;

  barrier_bus_initiator #(
    .NB_CORES(NB), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .CORE_ID(2), .TIMEOUT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_trig_mask_i(cmd_trig), .cmd_tgt_mask_i(cmd_tgt), .cmd_timeout_i(cmd_timeout),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
    .barrier_event_i(barrier_event),
    .bus_req_o(bus_req), .bus_add_o(bus_add), .bus_wen_o(bus_wen), .bus_wdata_o(bus_wdata),
    .bus_be_o(bus_be), .bus_gnt_i(bus_gnt), .bus_r_valid_i(bus_r_valid), .bus_r_rdata_i(bus_r_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t exp_txn[$];
  txn_t obs_txn[$];
  rsp_t exp_rsp[$];
  rsp_t obs_rsp[$];
  int txn_rd = 0;
  int rsp_rd = 0;
  int total = 0;
  int bad = 0;

  // slave model knobs and observations
  int          gnt_delay = 0;
  int          rv_delay = 1;
  logic        spurious_rv = 1'b0;
  logic [31:0] rd_word = 32'h0;
  int          stab_err = 0;
  int          req_cycles = 0;
  int          s_state = 0;
  int          s_cnt = 0;
  txn_t        held;

  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_gnt = 1'b0;
      bus_r_valid = 1'b0;
      s_state = 0;
    end else begin
      bus_gnt = 1'b0;
      bus_r_valid = 1'b0;
      bus_r_rdata = 32'hDEAD_BEEF;
      if (bus_req) req_cycles++;
      case (s_state)
        0: if (bus_req) begin
          held = '{bus_add, bus_wen, bus_wdata, bus_be};
          if (gnt_delay == 0) begin
            bus_gnt = 1'b1; bus_r_valid = spurious_rv; obs_txn.push_back(held);
            s_cnt = rv_delay; s_state = 2;
          end else begin
            s_cnt = gnt_delay; s_state = 1;
          end
        end
        1: begin
          if (bus_req !== 1'b1 || bus_add !== held.add || bus_wen !== held.wen || bus_wdata !== held.wdata)
            stab_err++;
          s_cnt--;
          if (s_cnt == 0) begin
            bus_gnt = 1'b1; bus_r_valid = spurious_rv; obs_txn.push_back(held);
            s_cnt = rv_delay; s_state = 2;
          end
        end
        2: begin
          s_cnt--;
          if (s_cnt == 0) begin
            bus_r_valid = 1'b1; bus_r_rdata = rd_word; s_state = 0;
          end
        end
        default: s_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_ni && rsp_valid) obs_rsp.push_back('{rsp_data, rsp_error, 32'(cyc)});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [NB-1:0] trig, input logic [NB-1:0] tgt,
                       input logic [15:0] to);
    cmd_op = op; cmd_trig = trig; cmd_tgt = tgt; cmd_timeout = to; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_trig = ~trig; cmd_tgt = ~tgt; cmd_timeout = 16'd1;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (obs_rsp.size() <= rsp_rd && n < 200) begin step(); n++; end
    ok = (obs_rsp.size() > rsp_rd);
  endtask

  task automatic wait_rv(output int r);
    int n = 0;
    while (bus_r_valid !== 1'b1 && n < 50) begin step(); n++; end
    r = cyc;
    total++;
    if (bus_r_valid !== 1'b1) begin bad++; $display("FAIL rv_wait: r_valid=%b required 1", bus_r_valid); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; step(); step(); rst_ni = 1'b1; step();
    total += 8;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h required 00", rsp_data); end
    if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_rsp_error: got %b required 0", rsp_error); end
    if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b required 0", bus_req); end
    if (bus_add !== 32'h0) begin bad++; $display("FAIL reset_add: got %h required 0", bus_add); end
    if (bus_wen !== 1'b1) begin bad++; $display("FAIL reset_wen: got %b required 1", bus_wen); end
    if (bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h required 0", bus_wdata); end
  endtask

  task automatic test_config(input logic [NB-1:0] trig, input logic [NB-1:0] tgt);
    bit ok; rsp_t o, e; txn_t ot, et;
    gnt_delay = 0; rv_delay = 1; spurious_rv = 1'b1;
    exp_txn.push_back('{BASE, 1'b0, {24'h0, trig}, 4'hF});
    exp_txn.push_back('{BASE + 32'h0C, 1'b0, {24'h0, tgt}, 4'hF});
    exp_rsp.push_back('{8'h00, 1'b0, 32'hFFFF_FFFF});
    issue(2'b00, trig, tgt, 16'd0);
    wait_rsp(ok);
    spurious_rv = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL cfg_rsp_timeout: no rsp_valid, required one"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++; e = exp_rsp.pop_front();
      if (o.data !== e.data || o.err !== e.err) begin
        bad++; $display("FAIL cfg_rsp: data=%h err=%b required data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
    total++;
    if (obs_txn.size() - txn_rd != 2) begin
      bad++; $display("FAIL cfg_txn_count: got %0d required 2", obs_txn.size() - txn_rd);
    end
    while (exp_txn.size() > 0 && txn_rd < obs_txn.size()) begin
      et = exp_txn.pop_front(); ot = obs_txn[txn_rd]; txn_rd++;
      total++;
      if (ot !== et) begin bad++; $display("FAIL cfg_txn: got %h required %h", ot, et); end
    end
    exp_txn.delete(); exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_arrive_latency();
    bit ok; rsp_t o; txn_t ot; int c0; int r;
    gnt_delay = 0; rv_delay = 1;
    c0 = cyc;
    exp_rsp.push_back('{8'h00, 1'b0, 32'(c0 + 4)});
    exp_txn.push_back('{BASE + 32'h10, 1'b0, 32'h4, 4'hF});
    issue(2'b01, 8'h00, 8'h00, 16'd0);
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b required 0", cmd_ready); end
    wait_rv(r);
    barrier_event = 1'b1; step(); barrier_event = 1'b0;
    wait_rsp(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL lat_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o !== exp_rsp[0]) begin
        bad++; $display("FAIL lat_rsp: data=%h err=%b cyc=%0d required err=0 cyc=%0d", o.data, o.err, o.c, c0 + 4);
      end
    end
    total++;
    if (txn_rd >= obs_txn.size()) begin bad++; $display("FAIL lat_txn: none, required %h", exp_txn[0]); end
    else begin
      ot = obs_txn[txn_rd]; txn_rd++;
      if (ot !== exp_txn[0]) begin bad++; $display("FAIL lat_txn: got %h required %h", ot, exp_txn[0]); end
    end
    exp_txn.delete(); exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_arrive_stall();
    bit ok; rsp_t o; txn_t ot; int r; int se0; int rc0;
    gnt_delay = 3; rv_delay = 1; se0 = stab_err; rc0 = req_cycles;
    exp_txn.push_back('{BASE + 32'h10, 1'b0, 32'h4, 4'hF});
    issue(2'b01, 8'h00, 8'h00, 16'd0);
    wait_rv(r);
    exp_rsp.push_back('{8'h00, 1'b0, 32'(r + 6)});
    for (int i = 0; i < 5; i++) step();
    barrier_event = 1'b1; step(); barrier_event = 1'b0;
    wait_rsp(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL stall_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o !== exp_rsp[0]) begin
        bad++; $display("FAIL stall_rsp: err=%b cyc=%0d required err=0 cyc=%0d", o.err, o.c, r + 6);
      end
    end
    if (stab_err != se0) begin bad++; $display("FAIL stall_stable: %0d changes, required 0", stab_err - se0); end
    if (req_cycles - rc0 != 4) begin bad++; $display("FAIL stall_req_cycles: got %0d required 4", req_cycles - rc0); end
    if (txn_rd >= obs_txn.size()) begin bad++; $display("FAIL stall_txn: none"); end
    else begin
      ot = obs_txn[txn_rd]; txn_rd++;
      if (ot !== exp_txn[0]) begin bad++; $display("FAIL stall_txn: got %h required %h", ot, exp_txn[0]); end
    end
    exp_txn.delete(); exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_event_at_gnt();
    bit ok; rsp_t o; int r; int n = 0;
    gnt_delay = 2; rv_delay = 3;
    issue(2'b01, 8'h00, 8'h00, 16'd0);
    while (bus_gnt !== 1'b1 && n < 20) begin step(); n++; end
    barrier_event = 1'b1; step(); barrier_event = 1'b0;
    wait_rv(r);
    exp_rsp.push_back('{8'h00, 1'b0, 32'(r + 2)});
    wait_rsp(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gnt_evt_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o !== exp_rsp[0]) begin
        bad++; $display("FAIL gnt_evt_rsp: err=%b cyc=%0d required err=0 cyc=%0d", o.err, o.c, r + 2);
      end
    end
    exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_timeout(input bit with_event);
    bit ok; rsp_t o; int r;
    gnt_delay = 2; rv_delay = 2;
    barrier_event = 1'b1; step(); barrier_event = 1'b0;
    issue(2'b01, 8'h00, 8'h00, 16'd10);
    barrier_event = 1'b1; step(); barrier_event = 1'b0;
    wait_rv(r);
    exp_rsp.push_back('{8'h00, !with_event, 32'(r + 11)});
    if (with_event) begin
      for (int i = 0; i < 10; i++) step();
      barrier_event = 1'b1; step(); barrier_event = 1'b0;
    end
    wait_rsp(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o !== exp_rsp[0]) begin
        bad++; $display("FAIL timeout_rsp(ev=%0d): err=%b cyc=%0d required err=%b cyc=%0d",
                        with_event, o.err, o.c, !with_event, r + 11);
      end
    end
    exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_read(input logic [31:0] word, input logic [NB-1:0] expd);
    bit ok; rsp_t o; txn_t ot;
    gnt_delay = 1; rv_delay = 2; rd_word = word;
    exp_rsp.push_back('{expd, 1'b0, 32'hFFFF_FFFF});
    exp_txn.push_back('{BASE + 32'h04, 1'b1, 32'h0, 4'hF});
    issue(2'b10, 8'h00, 8'h00, 16'd0);
    wait_rsp(ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL read_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o.data !== exp_rsp[0].data || o.err !== 1'b0) begin
        bad++; $display("FAIL read_rsp: data=%h err=%b required data=%h err=0", o.data, o.err, exp_rsp[0].data);
      end
    end
    if (txn_rd >= obs_txn.size()) begin bad++; $display("FAIL read_txn: none"); end
    else begin
      ot = obs_txn[txn_rd]; txn_rd++;
      if (ot.add !== exp_txn[0].add || ot.wen !== 1'b1 || ot.be !== 4'hF) begin
        bad++; $display("FAIL read_txn: add=%h wen=%b be=%h required add=%h wen=1 be=f", ot.add, ot.wen, ot.be, exp_txn[0].add);
      end
    end
    exp_txn.delete(); exp_rsp.delete(); txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
    step();
  endtask

  task automatic test_reserved();
    bit ok; rsp_t o; int rc0; int c0;
    rc0 = req_cycles;
    total++;
    if (rsp_data !== 8'h5A) begin bad++; $display("FAIL rsp_data_hold: got %h required 5a", rsp_data); end
    c0 = cyc;
    exp_rsp.push_back('{8'h00, 1'b1, 32'(c0 + 1)});
    issue(2'b11, 8'hFF, 8'hFF, 16'd0);
    wait_rsp(ok);
    step(); step();
    total += 2;
    if (!ok) begin bad++; $display("FAIL rsvd_rsp_timeout: no rsp_valid"); end
    else begin
      o = obs_rsp[rsp_rd]; rsp_rd++;
      if (o !== exp_rsp[0]) begin
        bad++; $display("FAIL rsvd_rsp: data=%h err=%b cyc=%0d required data=00 err=1 cyc=%0d", o.data, o.err, o.c, c0 + 1);
      end
    end
    if (req_cycles != rc0) begin bad++; $display("FAIL rsvd_no_req: req cycles %0d required 0", req_cycles - rc0); end
    exp_rsp.delete(); rsp_rd = obs_rsp.size();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    gnt_delay = 4; rv_delay = 1;
    issue(2'b00, 8'h11, 8'h22, 16'd0);
    while (!(bus_req === 1'b1 && bus_add === BASE + 32'h0C) && n < 40) begin step(); n++; end
    total += 4;
    if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_reach_tgt: req=%b add=%h required req=1 add=%h", bus_req, bus_add, BASE + 32'h0C); end
    rst_ni = 1'b0;
    #1;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got %b required 0", bus_req); end
    step(); step();
    rst_ni = 1'b1;
    step();
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b required 1", cmd_ready); end
    for (int i = 0; i < 10; i++) step();
    if (obs_rsp.size() != rsp_rd) begin bad++; $display("FAIL mid_no_rsp: %0d responses required 0", obs_rsp.size() - rsp_rd); end
    txn_rd = obs_txn.size(); rsp_rd = obs_rsp.size();
  endtask

  initial begin
    test_reset();
    test_config(8'h0F, 8'h0F);
    test_config(8'h3C, 8'hC3);
    test_arrive_latency();
    test_arrive_stall();
    test_event_at_gnt();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_read(32'h0000_00A5, 8'hA5);
    test_read(32'hFFFF_FF5A, 8'h5A);
    test_reserved();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
